// File: rtl/debounce_defs.sv
// Shared width helpers and board-level debounce constants for the button/switch debouncers.
package debounce_defs;

   // 100 MHz board clock: a 625 us tick times 16 ticks gives a ~10 ms debounce window.
   localparam int unsigned CLK_HZ             = 100_000_000;
   localparam int unsigned BOARD_PRESCALE     = 62_500;
   localparam int unsigned BOARD_STABLE_TICKS = 16;

   // Bits needed to hold the values 0..n-1, never less than one bit.
   function automatic int unsigned width_of(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   // Bits for a counter that must reach STABLE_TICKS-1, sized as $clog2(STABLE_TICKS+1).
   function automatic int unsigned cnt_width(input int unsigned stable_ticks);
      return width_of(stable_ticks + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser, stability counter, level register and edge strobes.
module debounce_channel
   import debounce_defs::*;
#(
   parameter int unsigned STABLE_TICKS = 16,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter logic        INIT_LEVEL   = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   input  logic tick,
   output logic dout,
   output logic rise,
   output logic fall,
   output logic change_next
);

   localparam int unsigned CW = cnt_width(STABLE_TICKS);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   dout_d;
   logic                   s;

   assign s = sync[SYNC_STAGES-1];

   // D input of rise|fall, so the bank can register any_change in the same cycle.
   assign change_next = dout ^ dout_d;

   // NOTE: every register here is written with <= so all stages sample pre-edge values;
   // a blocking assignment in the shift would collapse the synchroniser to a single flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync   <= {SYNC_STAGES{INIT_LEVEL}};
         cnt    <= '0;
         dout   <= INIT_LEVEL;
         dout_d <= INIT_LEVEL;
         rise   <= 1'b0;
         fall   <= 1'b0;
      end else begin
         sync   <= {sync[SYNC_STAGES-2:0], din};
         dout_d <= dout;
         rise   <= dout & ~dout_d;
         fall   <= ~dout & dout_d;

         if (s == dout) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == CW'(STABLE_TICKS - 1)) begin
               dout <= ~dout;
               cnt  <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debouncers sharing one prescaler tick, with a registered any_change flag.
module debounce_bank
   import debounce_defs::*;
#(
   parameter int unsigned          CHANNELS     = 4,
   parameter int unsigned          STABLE_TICKS = 16,
   parameter int unsigned          PRESCALE     = 1000,
   parameter int unsigned          SYNC_STAGES  = 2,
   parameter logic [CHANNELS-1:0]  INIT_LEVEL   = {CHANNELS{1'b0}}
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [CHANNELS-1:0] din,
   output logic [CHANNELS-1:0] dout,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic                any_change
);

   localparam int unsigned PW = width_of(PRESCALE);

   logic [PW-1:0]       pre_cnt;
   logic                tick;
   logic [CHANNELS-1:0] change_next;

   // With PRESCALE=1 the counter sits at zero and tick is permanently high.
   assign tick = (pre_cnt == PW'(PRESCALE - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + 1'b1;
      end
   end

   for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
      debounce_channel #(
         .STABLE_TICKS (STABLE_TICKS),
         .SYNC_STAGES  (SYNC_STAGES),
         .INIT_LEVEL   (INIT_LEVEL[i])
      ) u_ch (
         .clk         (clk),
         .rst_n       (rst_n),
         .din         (din[i]),
         .tick        (tick),
         .dout        (dout[i]),
         .rise        (rise[i]),
         .fall        (fall[i]),
         .change_next (change_next[i])
      );
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         any_change <= 1'b0;
      end else begin
         any_change <= |change_next;
      end
   end

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: reset, clean press, bounce, multi-channel, prescaler phases.
module tb_debounce_bank;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] din_r, din_a, din_b;
   logic [3:0] dout_r, rise_r, fall_r;
   logic [3:0] dout_a, rise_a, fall_a;
   logic [3:0] dout_b, rise_b, fall_b;
   logic       any_r, any_a, any_b;

   int errors = 0;
   int checks = 0;
   int ecnt;

   always #5 clk = ~clk;

   // dut_r: non-zero reset level; dut_a: fast window; dut_b: prescaled window.
   debounce_bank #(.CHANNELS(4), .STABLE_TICKS(4), .PRESCALE(1), .SYNC_STAGES(2),
                   .INIT_LEVEL(4'b0101)) dut_r (
      .clk(clk), .rst_n(rst_n), .din(din_r), .dout(dout_r),
      .rise(rise_r), .fall(fall_r), .any_change(any_r));

   debounce_bank #(.CHANNELS(4), .STABLE_TICKS(4), .PRESCALE(1), .SYNC_STAGES(2),
                   .INIT_LEVEL(4'b0000)) dut_a (
      .clk(clk), .rst_n(rst_n), .din(din_a), .dout(dout_a),
      .rise(rise_a), .fall(fall_a), .any_change(any_a));

   debounce_bank #(.CHANNELS(4), .STABLE_TICKS(3), .PRESCALE(8), .SYNC_STAGES(2),
                   .INIT_LEVEL(4'b0000)) dut_b (
      .clk(clk), .rst_n(rst_n), .din(din_b), .dout(dout_b),
      .rise(rise_b), .fall(fall_b), .any_change(any_b));

   // Index of the next rising edge since reset release; prescaler ticks on edges with index%8==7.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ecnt <= 0;
      else        ecnt <= ecnt + 1;
   end

   typedef struct {
      logic [3:0] din;
      logic [3:0] dout;
      logic [3:0] rise;
      logic [3:0] fall;
      logic       any;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int k, e0n, flip, expf, ticks, dly;
      logic old;

      // Clean press on ch0 (e0..e7), then bounce on ch1 (3 high, 1 low, then high).
      for (int i = 0; i < 8; i++) begin
         vecs[i] = '{4'b0001, (i >= 5) ? 4'b0001 : 4'b0000,
                     (i == 6) ? 4'b0001 : 4'b0000, 4'b0000, (i == 6)};
      end
      for (int i = 8; i < 20; i++) begin
         vecs[i] = '{(i == 11) ? 4'b0001 : 4'b0011, (i >= 17) ? 4'b0011 : 4'b0001,
                     (i == 18) ? 4'b0010 : 4'b0000, 4'b0000, (i == 18)};
      end

      // Reset held with inputs toggling.
      rst_n = 1'b0;
      din_r = 4'b0000; din_a = 4'b0000; din_b = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         din_r = ~din_r; din_a = ~din_a; din_b = ~din_b;
         step();
      end
      check("rst_dout_r", dout_r, 4'b0101);
      check("rst_rise_r", rise_r, 4'b0000);
      check("rst_fall_r", fall_r, 4'b0000);
      check("rst_any_r",  any_r,  1'b0);
      check("rst_dout_a", dout_a, 4'b0000);
      check("rst_dout_b", dout_b, 4'b0000);
      din_r = 4'b0101; din_a = 4'b0000; din_b = 4'b0000;
      rst_n = 1'b1;
      step();
      step();
      check("idle_dout_r", dout_r, 4'b0101);
      check("idle_any_r",  any_r,  1'b0);

      // Table: clean press and bounce abort on dut_a.
      for (int i = 0; i < 20; i++) begin
         din_a = vecs[i].din;
         step();
         check($sformatf("vec%0d_dout", i), dout_a, vecs[i].dout);
         check($sformatf("vec%0d_rise", i), rise_a, vecs[i].rise);
         check($sformatf("vec%0d_fall", i), fall_a, vecs[i].fall);
         check($sformatf("vec%0d_any",  i), any_a,  vecs[i].any);
      end

      // Simultaneous: ch1 rises and ch2 falls on dut_r.
      din_r = 4'b0011;
      for (int e = 0; e < 8; e++) begin
         step();
         check($sformatf("multi%0d_dout", e), dout_r, (e >= 5) ? 4'b0011 : 4'b0101);
         check($sformatf("multi%0d_rise", e), rise_r, (e == 6) ? 4'b0010 : 4'b0000);
         check($sformatf("multi%0d_fall", e), fall_r, (e == 6) ? 4'b0100 : 4'b0000);
         check($sformatf("multi%0d_any",  e), any_r,  (e == 6));
      end

      // Reset mid-transition: ch3 of dut_a two counts in; asynchronous assertion between edges.
      din_a = 4'b1011;
      for (int e = 0; e < 4; e++) step();
      check("mid_dout_a_pre", dout_a, 4'b0011);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_dout_r", dout_r, 4'b0101);
      check("async_dout_a", dout_a, 4'b0000);
      din_r = 4'b0101;
      for (int e = 0; e < 3; e++) begin
         step();
         check($sformatf("inrst%0d_strobe_a", e), {rise_a, fall_a, 3'b000, any_a}, 12'h000);
         check($sformatf("inrst%0d_strobe_r", e), {rise_r, fall_r, 3'b000, any_r}, 12'h000);
      end
      rst_n = 1'b1;
      for (int r = 0; r < 8; r++) begin
         step();
         check($sformatf("rel%0d_dout_a", r), dout_a, (r >= 5) ? 4'b1011 : 4'b0000);
         check($sformatf("rel%0d_rise_a", r), rise_a, (r == 6) ? 4'b1011 : 4'b0000);
         check($sformatf("rel%0d_fall_a", r), fall_a, 4'b0000);
         check($sformatf("rel%0d_any_a",  r), any_a,  (r == 6));
         check($sformatf("rel%0d_dout_r", r), dout_r, 4'b0101);
         check($sformatf("rel%0d_any_r",  r), any_r,  1'b0);
      end

      // Prescaler sweep on dut_b ch0 across all eight phases.
      for (int ph = 0; ph < 8; ph++) begin
         for (int g = 0; g < 16 && (ecnt % 8) != ph; g++) step();
         e0n = ecnt;
         k   = e0n + 1;
         din_b[0] = ~din_b[0];
         old   = dout_b[0];
         ticks = 0;
         expf  = -1;
         for (int n = k + 1; n < k + 40; n++) begin
            if ((n % 8) == 7) ticks++;
            if (ticks == 3 && expf < 0) expf = n;
         end
         flip = -1;
         for (int t = 0; t < 40; t++) begin
            step();
            if (dout_b[0] !== old) begin
               flip = ecnt - 1;
               break;
            end
         end
         dly = flip - k;
         check($sformatf("pre%0d_flip_edge", ph), flip, expf);
         check($sformatf("pre%0d_delay_ok", ph), (dly >= 17 && dly <= 24), 1'b1);
         check($sformatf("pre%0d_other_ch", ph), dout_b[3:1], 3'b000);
         step();
         check($sformatf("pre%0d_strobe", ph), {rise_b[0], fall_b[0], any_b},
               old ? 3'b011 : 3'b101);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel, parametrised debouncer for the board's push-buttons and slide switches ahead of the OLED demo control logic. Each channel synchronises its asynchronous input and updates its debounced output only after the input has been stable for a programmable number of prescaler ticks. Each channel also emits single-cycle rise/fall strobes. A shared prescaler keeps per-channel counters narrow, so long debounce windows cost few flops per channel.

## Interface
- CHANNELS, 4: number of independent input channels (≥1).
- STABLE_TICKS, 16: prescaler ticks the synchronised input must hold before the output flips (≥1).
- PRESCALE, 1000: clk cycles per tick (≥1; 1 means a tick every cycle).
- SYNC_STAGES, 2: synchroniser flops per channel (≥2).
- INIT_LEVEL, {CHANNELS{1'b0}}: per-channel reset value of synchroniser and output, CHANNELS bits wide.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  CHANNELS  raw asynchronous inputs.
- dout  out  CHANNELS  debounced levels.
- rise  out  CHANNELS  one-cycle pulse in the cycle dout[i] goes 0→1.
- fall  out  CHANNELS  one-cycle pulse in the cycle dout[i] goes 1→0.
- any_change  out  1  OR of rise|fall, registered with them.

## Operation
- Reset (rst_n low, asynchronous): synchroniser flops and dout = INIT_LEVEL; per-channel counters = 0; prescaler = 0; rise, fall, any_change = 0.
- Prescaler: counter runs 0..PRESCALE-1 and wraps. tick = (count == PRESCALE-1). For PRESCALE=1, tick is constantly 1. Width is $clog2(PRESCALE), minimum 1 bit.
- Per channel, s = last synchroniser stage. State is {dout[i], cnt[i]}, with cnt width $clog2(STABLE_TICKS+1).
  - Idle (s == dout): cnt forced to 0 every cycle. A bounce back aborts a transition immediately.
  - Transition (s != dout):
    - On tick with cnt == STABLE_TICKS-1: dout toggles, cnt ← 0, and the matching rise/fall asserts the next cycle.
    - On any other tick: cnt increments.
    - Without a tick: cnt holds.
- cnt never exceeds STABLE_TICKS-1; no wrap-around is possible.
- rise/fall are registered; each is high exactly one cycle per dout edge and never both on one channel.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own strobes in the same cycle; any_change is high once for that cycle.
- Reset mid-transition: the in-flight count is discarded and no strobe is emitted. dout returns to INIT_LEVEL even if it had already toggled.

## Timing
- PRESCALE=1: din changes before edge e0, with e1, e2, … the following rising edges.
  - s differs after edge e(SYNC_STAGES-1).
  - dout flips at edge e(SYNC_STAGES-1+STABLE_TICKS).
  - The rise/fall strobe is high during the cycle after dout changes.
- PRESCALE>1: required stable time is between (STABLE_TICKS-1)*PRESCALE+1 and STABLE_TICKS*PRESCALE cycles of s, depending on prescaler phase. The flip always occurs on a tick edge.
- Output pulses are never shorter than one clk cycle. No combinational path from din to any output.

## Structure
- Shared include/package debounce_defs: $clog2-based width helper functions and the default STABLE_TICKS/PRESCALE constants for the board's 100 MHz clock (≈10 ms window).
- One sub-module, debounce_channel: synchroniser, counter, level and strobe registers for one bit, taking the shared tick. debounce_bank holds the prescaler, generate-instantiates CHANNELS copies, and registers the any_change OR.

## Test plan
- Reset: INIT_LEVEL=4'b0101, hold rst_n low with din toggling → dout=4'b0101, rise=fall=0, any_change=0. Assert rst_n asynchronously mid-cycle → outputs change without a clock edge.
- Clean press: PRESCALE=1, STABLE_TICKS=4, SYNC_STAGES=2, din[0] 0→1 before e0 → dout[0]=1 after e5. rise[0] high exactly one cycle (after e6), fall stays 0.
- Bounce abort: same parameters, din[0] high 3 cycles, low 1 cycle, then high → no flip until 4 consecutive stable synchronised cycles after the last edge.
- Simultaneous multi-channel: ch1 rises and ch2 falls in the same cycle → rise[1] and fall[2] assert in the same cycle; any_change high for one cycle only. Other channels are unaffected.
- Prescaler: PRESCALE=8, STABLE_TICKS=3, sweep the input change across all 8 prescaler phases → flip occurs 17..24 cycles after s changes, always on a tick edge.
- Reset mid-transition: PRESCALE=1, STABLE_TICKS=4, drop rst_n 2 cycles into a count → no strobe; after release dout=INIT_LEVEL. A still-active input needs a full 4 stable cycles again.
